// File: rtl/vp_kbd_pkg.sv
// Shared types and key-code translation for the keyboard event queue feeding vp_keymap.
package vp_kbd_pkg;

    typedef struct packed {
        logic       released;
        logic [7:0] ascii;
    } kbd_evt_t;

    typedef enum logic [1:0] {StIdle, StPresent, StWaitAck, StGap} kbd_state_e;

    localparam logic [7:0] KEY_YES   = 8'h11;
    localparam logic [7:0] KEY_NO    = 8'h12;
    localparam logic [7:0] KEY_ENTER = 8'd10;
    localparam logic [7:0] KEY_BKSP  = 8'd8;

    // Set-2 scancode to ascii; the extended bit is masked so E0-prefixed keys alias.
    function automatic logic [7:0] ps2_to_ascii(input logic [8:0] code);
        logic [7:0] a;
        case (code & 9'h0ff)
            9'h045: a = "0";
            9'h016: a = "1";
            9'h01e: a = "2";
            9'h026: a = "3";
            9'h025: a = "4";
            9'h02e: a = "5";
            9'h036: a = "6";
            9'h03d: a = "7";
            9'h03e: a = "8";
            9'h046: a = "9";
            9'h01c: a = "a";
            9'h032: a = "b";
            9'h021: a = "c";
            9'h023: a = "d";
            9'h024: a = "e";
            9'h02b: a = "f";
            9'h034: a = "g";
            9'h033: a = "h";
            9'h043: a = "i";
            9'h03b: a = "j";
            9'h042: a = "k";
            9'h04b: a = "l";
            9'h03a: a = "m";
            9'h031: a = "n";
            9'h044: a = "o";
            9'h04d: a = "p";
            9'h015: a = "q";
            9'h02d: a = "r";
            9'h01b: a = "s";
            9'h02c: a = "t";
            9'h03c: a = "u";
            9'h02a: a = "v";
            9'h01d: a = "w";
            9'h022: a = "x";
            9'h035: a = "y";
            9'h01a: a = "z";
            9'h029: a = " ";
            9'h079: a = "+";
            9'h04e: a = "-";
            9'h07b: a = "-";
            9'h07c: a = "*";
            9'h04a: a = "/";
            9'h055: a = "=";
            9'h01f: a = KEY_YES;
            9'h027: a = KEY_NO;
            9'h05a: a = KEY_ENTER;
            9'h066: a = KEY_BKSP;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    function automatic logic [7:0] joy_to_ascii(input logic [3:0] idx);
        logic [7:0] a;
        if (idx < 4'd9) begin
            a = 8'h31 + {4'h0, idx};
        end else if (idx == 4'd9) begin
            a = "0";
        end else begin
            a = 8'h00;
        end
        return a;
    endfunction

endpackage

// File: rtl/vp_kbd_fifo.sv
// Synchronous event FIFO; push/pop are guarded so level never wraps.
module vp_kbd_fifo
    import vp_kbd_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     res_i,
    input  logic                     push_i,
    input  kbd_evt_t                 data_i,
    input  logic                     pop_i,
    output kbd_evt_t                 head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned LevelW = PtrW + 1;

    kbd_evt_t              mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [LevelW-1:0]     level_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LevelW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (do_push && !do_pop) begin
                level_q <= level_q + LevelW'(1);
            end else if (!do_push && do_pop) begin
                level_q <= level_q - LevelW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/vp_kbd_event_queue.sv
// Merges PS/2 and gamepad-numpad key events into a queue and hands them to vp_keymap
// one at a time with a strobe/ack handshake and an ack timeout.
module vp_kbd_event_queue
    import vp_kbd_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned ACK_TIMEOUT = 4096,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic                     clk_i,
    input  logic                     res_i,
    input  logic [10:0]              ps2_key_i,
    input  logic [9:0]               joy_numpad_i,
    output logic                     rx_data_ready_o,
    output logic [7:0]               rx_ascii_o,
    output logic                     rx_released_o,
    input  logic                     rx_read_i,
    output logic                     overflow_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned CntMax = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(ACK_TIMEOUT - 1);
    localparam logic [CntW-1:0] GapLast     = CntW'(GAP_CYCLES - 1);

    logic            toggle_q;
    logic            ps2_evt_q;
    logic [9:0]      ps2_code_q;
    logic [9:0]      joy_in_q;
    logic [9:0]      joy_q;
    logic            overflow_q;
    kbd_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    logic            ready_q;

    logic [7:0]      ps2_ascii;
    logic            ps2_valid;
    logic [9:0]      joy_diff;
    logic [3:0]      joy_idx;
    logic            joy_take;
    logic            ovf_set;
    logic            push;
    logic            pop;
    logic            can_push;
    kbd_evt_t        push_evt;
    kbd_evt_t        head;
    logic            fifo_full;
    logic            fifo_empty;

    assign ps2_ascii = ps2_to_ascii(ps2_code_q[8:0]);
    assign ps2_valid = ps2_evt_q && (ps2_ascii != 8'h00);
    assign joy_diff  = joy_in_q ^ joy_q;

    always_comb begin
        joy_idx = '0;
        for (int i = 9; i >= 0; i--) begin
            if (joy_diff[i]) joy_idx = 4'(i);
        end
    end

    assign pop = ((state_q == StPresent) && rx_read_i) ||
                 ((state_q == StWaitAck) && (rx_read_i || (cnt_q == TimeoutLast)));
    assign can_push = ~fifo_full | pop;

    // PS/2 has priority and is lossy on full; joystick changes stay pending in joy_q.
    always_comb begin
        push     = 1'b0;
        push_evt = '0;
        joy_take = 1'b0;
        ovf_set  = 1'b0;
        if (ps2_valid) begin
            push     = can_push;
            ovf_set  = ~can_push;
            push_evt = '{released: ~ps2_code_q[9], ascii: ps2_ascii};
        end else if ((joy_diff != '0) && can_push) begin
            push     = 1'b1;
            joy_take = 1'b1;
            push_evt = '{released: ~joy_in_q[joy_idx], ascii: joy_to_ascii(joy_idx)};
        end
    end

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            toggle_q   <= ps2_key_i[10];
            ps2_evt_q  <= 1'b0;
            ps2_code_q <= '0;
            joy_in_q   <= '0;
            joy_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            toggle_q   <= ps2_key_i[10];
            ps2_evt_q  <= ps2_key_i[10] ^ toggle_q;
            ps2_code_q <= ps2_key_i[9:0];
            joy_in_q   <= joy_numpad_i;
            if (joy_take) joy_q[joy_idx] <= joy_in_q[joy_idx];
            if (ovf_set)  overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        state_q <= StPresent;
                        ready_q <= 1'b1;
                    end
                end
                StPresent: begin
                    cnt_q   <= '0;
                    state_q <= rx_read_i ? StGap : StWaitAck;
                end
                StWaitAck: begin
                    if (rx_read_i || (cnt_q == TimeoutLast)) begin
                        cnt_q   <= '0;
                        state_q <= StGap;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StGap: begin
                    if (cnt_q == GapLast) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    vp_kbd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .res_i   (res_i),
        .push_i  (push),
        .data_i  (push_evt),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    assign rx_data_ready_o = ready_q;
    assign rx_ascii_o      = head.ascii;
    assign rx_released_o   = head.released;
    assign overflow_o      = overflow_q;

endmodule
